coin_acceptor: RTL and testbench

Front end of the vending machine's coin path. It takes the three raw, asynchronous, bouncy coin-sensor levels from the coin mech and turns each physical coin into exactly one clean, one-cycle `N_in`/`D_in`/`Q_in` pulse for `FSM_VendingMachine`. It rejects glitches, multi-sensor hits and coins inserted while the FSM is not accepting. It sits between the board pins and the vending FSM, in the same clock domain as the FSM.

---
 rtl/coin_acceptor_pkg.sv | 38 +++
 rtl/coin_acceptor_sync2.sv | 34 +++
 rtl/coin_acceptor.sv | 193 +++++++++++++++++++
 tb/tb_coin_acceptor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// -----------------------------------------------------------------------------
// coin_acceptor_pkg
// Shared definitions for the coin path front end:
//   - state_e          : acceptor state machine states
//   - COIN_*_BIT       : bit positions of each coin in the 3-bit sensor vector
//   - COIN_*_VALUE     : coin values in cents, for a downstream credit block
//   - coin_is_one_hot  : true when exactly one sensor is active
// -----------------------------------------------------------------------------
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int unsigned COIN_N_BIT = 32'd0;
  localparam int unsigned COIN_D_BIT = 32'd1;
  localparam int unsigned COIN_Q_BIT = 32'd2;

  localparam int unsigned COIN_N_VALUE = 32'd5;
  localparam int unsigned COIN_D_VALUE = 32'd10;
  localparam int unsigned COIN_Q_VALUE = 32'd25;

  // A coin is only credited when exactly one sensor saw it.
  function automatic logic coin_is_one_hot(input logic [2:0] v);
    logic r_hot;
    case (v)
      3'b001:  r_hot = 1'b1;
      3'b010:  r_hot = 1'b1;
      3'b100:  r_hot = 1'b1;
      default: r_hot = 1'b0;
    endcase
    return r_hot;
  endfunction

endpackage : coin_acceptor_pkg

// File: rtl/coin_acceptor_sync2.sv
// -----------------------------------------------------------------------------
// coin_acceptor_sync2
// One-bit, two-flop synchronizer bringing a raw coin-sensor level into the
// clk domain. Both flops clear asynchronously while i_rst_n is low.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input level
//   o_q     : synchronized level, two edges after capture
// -----------------------------------------------------------------------------
module coin_acceptor_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; r_meta may go metastable, r_sync is the settled copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : coin_acceptor_sync2

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Turns three bouncy, asynchronous coin-sensor levels into one clean one-cycle
// pulse per physical coin for the vending FSM. Glitches are dropped, coins
// seen by more than one sensor or inserted while the FSM cannot take credit
// are refused with a reject pulse, and a coin must be released (sensors quiet
// for DEBOUNCE_CYCLES+1 samples) before the next one can qualify.
// Parameters:
//   DEBOUNCE_CYCLES : stable samples needed to qualify a coin or a release (1..255)
//   CNT_W           : width of coin_count
// Ports:
//   clk                                : system clock, rising edge
//   reset                              : asynchronous active-low reset
//   coin_n_raw, coin_d_raw, coin_q_raw : raw sensor levels, active-high
//   enable                             : vending FSM can accept credit
//   N_in, D_in, Q_in                   : registered one-cycle coin pulses
//   reject                             : registered one-cycle refusal pulse
//   busy                               : acceptor is not idle
//   coin_count                         : accepted coins, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
  parameter int unsigned CNT_W           = 32'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_n_raw,
  input  logic             coin_d_raw,
  input  logic             coin_q_raw,
  input  logic             enable,
  output logic             N_in,
  output logic             D_in,
  output logic             Q_in,
  output logic             reject,
  output logic             busy,
  output logic [CNT_W-1:0] coin_count
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [2:0]       w_s;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_pat;
  logic [2:0]       w_pat_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_n_in;
  logic             r_d_in;
  logic             r_q_in;
  logic             r_reject;
  logic             w_n_in_nxt;
  logic             w_d_in_nxt;
  logic             w_q_in_nxt;
  logic             w_reject_nxt;
  logic [CNT_W-1:0] r_coin_count;
  logic [CNT_W-1:0] w_coin_count_nxt;

  coin_acceptor_sync2 u_sync_n (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (coin_n_raw),
    .o_q     (w_s[COIN_N_BIT])
  );

  coin_acceptor_sync2 u_sync_d (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (coin_d_raw),
    .o_q     (w_s[COIN_D_BIT])
  );

  coin_acceptor_sync2 u_sync_q (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (coin_q_raw),
    .o_q     (w_s[COIN_Q_BIT])
  );

  // Next-state, debounce counter and output-pulse logic.
  // The accept/reject decision is registered on the edge that enters DECIDE,
  // so the pulse is high for exactly the one DECIDE cycle. enable is looked
  // at only on that edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_pat_nxt        = r_pat;
    w_cnt_nxt        = r_cnt;
    w_n_in_nxt       = 1'b0;
    w_d_in_nxt       = 1'b0;
    w_q_in_nxt       = 1'b0;
    w_reject_nxt     = 1'b0;
    w_coin_count_nxt = r_coin_count;

    case (r_state)
      ST_IDLE: begin
        if (w_s != 3'b000) begin
          w_pat_nxt   = w_s;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = ST_QUAL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_QUAL: begin
        if (w_s == r_pat) begin
          if (r_cnt == DB_LIMIT) begin
            w_state_nxt = ST_DECIDE;
            if (coin_is_one_hot(r_pat) && enable) begin
              w_n_in_nxt       = r_pat[COIN_N_BIT];
              w_d_in_nxt       = r_pat[COIN_D_BIT];
              w_q_in_nxt       = r_pat[COIN_Q_BIT];
              w_coin_count_nxt = r_coin_count + CNT_W'(1);
            end else begin
              w_reject_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end else if (w_s == 3'b000) begin
          // Sensor dropped before qualifying: a glitch, forget it.
          w_state_nxt = ST_IDLE;
          w_pat_nxt   = 3'b000;
          w_cnt_nxt   = 8'd0;
        end else begin
          // Pattern changed to another non-zero value: restart on it.
          w_pat_nxt = w_s;
          w_cnt_nxt = 8'd1;
        end
      end

      ST_DECIDE: begin
        w_state_nxt = ST_RELEASE;
        w_cnt_nxt   = 8'd0;
      end

      ST_RELEASE: begin
        if (w_s == 3'b000) begin
          if (r_cnt == DB_LIMIT) begin
            w_state_nxt = ST_IDLE;
            w_pat_nxt   = 3'b000;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end else begin
          // Bounce or a coin still sitting in the sensor: restart the quiet count.
          w_cnt_nxt = 8'd0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_pat_nxt   = 3'b000;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State, qualification registers, output pulses and accepted-coin counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pat        <= 3'b000;
      r_cnt        <= 8'd0;
      r_n_in       <= 1'b0;
      r_d_in       <= 1'b0;
      r_q_in       <= 1'b0;
      r_reject     <= 1'b0;
      r_coin_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pat        <= w_pat_nxt;
      r_cnt        <= w_cnt_nxt;
      r_n_in       <= w_n_in_nxt;
      r_d_in       <= w_d_in_nxt;
      r_q_in       <= w_q_in_nxt;
      r_reject     <= w_reject_nxt;
      r_coin_count <= w_coin_count_nxt;
    end
  end

  assign N_in       = r_n_in;
  assign D_in       = r_d_in;
  assign Q_in       = r_q_in;
  assign reject     = r_reject;
  assign busy       = (r_state != ST_IDLE);
  assign coin_count = r_coin_count;

endmodule : coin_acceptor

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Directed and randomized stimulus for coin_acceptor. A reference model built
// on run lengths of the synchronized sensor vector (length of the current
// stable non-zero run, length of the quiet run after a decision) predicts the
// outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          coin_n_raw;
  logic          coin_d_raw;
  logic          coin_q_raw;
  logic          enable;
  logic          N_in;
  logic          D_in;
  logic          Q_in;
  logic          reject;
  logic          busy;
  logic [CW-1:0] coin_count;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_n_raw (coin_n_raw),
    .coin_d_raw (coin_d_raw),
    .coin_q_raw (coin_q_raw),
    .enable     (enable),
    .N_in       (N_in),
    .D_in       (D_in),
    .Q_in       (Q_in),
    .reject     (reject),
    .busy       (busy),
    .coin_count (coin_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] m_h1, m_h2;      // raw vector delayed by one and two edges
  bit         m_armed;         // free to qualify a new coin
  int         m_run_len;       // samples in the current stable non-zero run
  logic [2:0] m_run_pat;
  bit         m_in_decide;     // the edge after a decision is skipped
  int         m_zero_run;      // consecutive quiet samples after a decision
  int         m_count;
  logic       m_n, m_d, m_q, m_rej;

  task automatic model_clear();
    m_h1 = 3'b000; m_h2 = 3'b000;
    m_armed = 1'b1; m_run_len = 0; m_run_pat = 3'b000;
    m_in_decide = 1'b0; m_zero_run = 0; m_count = 0;
    m_n = 1'b0; m_d = 1'b0; m_q = 1'b0; m_rej = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    logic [2:0] raw;
    raw = {coin_q_raw, coin_d_raw, coin_n_raw};
    if (!reset) begin
      model_clear();
    end else begin
      s = m_h2; m_h2 = m_h1; m_h1 = raw;
      m_n = 1'b0; m_d = 1'b0; m_q = 1'b0; m_rej = 1'b0;
      if (m_armed) begin
        if (s == 3'b000) m_run_len = 0;
        else if (m_run_len > 0 && s == m_run_pat) m_run_len++;
        else begin m_run_pat = s; m_run_len = 1; end
        if (m_run_len == DB + 1) begin
          if ($countones(s) == 1 && enable) begin
            m_n = s[0]; m_d = s[1]; m_q = s[2];
            m_count = (m_count + 1) % (1 << CW);
          end else begin
            m_rej = 1'b1;
          end
          m_armed = 1'b0; m_in_decide = 1'b1; m_zero_run = 0; m_run_len = 0;
        end
      end else if (m_in_decide) begin
        m_in_decide = 1'b0; m_zero_run = 0;
      end else if (s == 3'b000) begin
        m_zero_run++;
        if (m_zero_run == DB + 1) m_armed = 1'b1;
      end else begin
        m_zero_run = 0;
      end
    end
  endtask

  // ---------------- observation ----------------
  int edge_no = 0;
  int cnt_n, cnt_d, cnt_q, cnt_rej;
  int first_pulse_edge;
  int seq_q[$];

  task automatic clear_obs();
    cnt_n = 0; cnt_d = 0; cnt_q = 0; cnt_rej = 0;
    first_pulse_edge = -1;
    seq_q.delete();
  endtask

  task automatic tick();
    logic          exp_busy;
    logic [CW-1:0] exp_cnt;
    @(posedge clk);
    edge_no++;
    model_step();
    #1;
    exp_busy = !m_armed || (m_run_len > 0);
    exp_cnt  = m_count[CW-1:0];
    check_val("outputs", {19'd0, N_in, D_in, Q_in, reject, busy, coin_count},
              {19'd0, m_n, m_d, m_q, m_rej, exp_busy, exp_cnt});
    if (N_in)   begin cnt_n++;   seq_q.push_back(1); end
    if (D_in)   begin cnt_d++;   seq_q.push_back(2); end
    if (Q_in)   begin cnt_q++;   seq_q.push_back(3); end
    if (reject) begin cnt_rej++; seq_q.push_back(4); end
    if ((N_in || D_in || Q_in || reject) && first_pulse_edge < 0) first_pulse_edge = edge_no;
  endtask

  task automatic hold(input logic [2:0] raw, input int n);
    {coin_q_raw, coin_d_raw, coin_n_raw} = raw;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         k;
    int         code;
    int         exp_code;
    logic [2:0] pat;
    int         hi;
    int         lo;

    reset = 1'b1;
    {coin_q_raw, coin_d_raw, coin_n_raw} = 3'b000;
    enable = 1'b1;
    model_clear();
    clear_obs();
    #2 reset = 1'b0;
    #1;
    check_val("reset_state", {19'd0, N_in, D_in, Q_in, reject, busy, coin_count}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    hold(3'b000, 3);

    // Clean nickel: pulse 6 edges after the first raw sample.
    clear_obs();
    k = edge_no + 1;
    hold(3'b001, 10);
    hold(3'b000, 20);
    check_val("nickel_latency", first_pulse_edge - k, 32'd6);
    check_val("nickel_pulses", cnt_n, 32'd1);
    check_val("nickel_others", cnt_d + cnt_q + cnt_rej, 32'd0);
    check_val("nickel_count", coin_count, 32'd1);
    check_val("nickel_busy", busy, 32'd0);

    // Short dime glitch: nothing at all.
    clear_obs();
    hold(3'b010, 3);
    hold(3'b000, 12);
    check_val("glitch_pulses", cnt_n + cnt_d + cnt_q + cnt_rej, 32'd0);
    check_val("glitch_count", coin_count, 32'd1);

    // Dime bouncing during release: exactly one D_in.
    clear_obs();
    hold(3'b010, 8);
    hold(3'b000, 1); hold(3'b010, 1); hold(3'b000, 1); hold(3'b010, 1);
    hold(3'b000, 15);
    check_val("bounce_d", cnt_d, 32'd1);
    check_val("bounce_others", cnt_n + cnt_q + cnt_rej, 32'd0);
    check_val("bounce_count", coin_count, 32'd2);

    // Two sensors at once: reject.
    clear_obs();
    hold(3'b110, 8);
    hold(3'b000, 15);
    check_val("multi_reject", cnt_rej, 32'd1);
    check_val("multi_coins", cnt_n + cnt_d + cnt_q, 32'd0);
    check_val("multi_count", coin_count, 32'd2);

    // Quarter while not accepting: reject.
    clear_obs();
    enable = 1'b0;
    hold(3'b100, 8);
    hold(3'b000, 15);
    enable = 1'b1;
    check_val("disabled_reject", cnt_rej, 32'd1);
    check_val("disabled_coins", cnt_n + cnt_d + cnt_q, 32'd0);
    check_val("disabled_count", coin_count, 32'd2);

    // N,D,N,D,N,D sequence from a fresh count.
    do_reset();
    clear_obs();
    exp_code = 0;
    for (int i = 0; i < 6; i++) begin
      hold((i % 2 == 0) ? 3'b001 : 3'b010, 8);
      hold(3'b000, 10);
      exp_code = exp_code * 8 + ((i % 2 == 0) ? 1 : 2);
    end
    hold(3'b000, 5);
    code = 0;
    foreach (seq_q[i]) code = code * 8 + seq_q[i];
    check_val("seq_len", seq_q.size(), 32'd6);
    check_val("seq_order", code, exp_code);
    check_val("seq_count", coin_count, 32'd6);

    // Reset two cycles into qualifying a quarter, sensor still high.
    clear_obs();
    hold(3'b100, 4);
    reset = 1'b0;
    #1;
    check_val("rst_async", {19'd0, N_in, D_in, Q_in, reject, busy, coin_count}, 32'd0);
    hold(3'b100, 2);
    check_val("rst_no_q", cnt_q, 32'd0);
    reset = 1'b1;
    hold(3'b100, 6);
    hold(3'b000, 15);
    check_val("rst_after_q", cnt_q, 32'd1);
    check_val("rst_after_count", coin_count, 32'd1);

    // Randomized coins, glitches, bounces and enable changes.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) < 7) pat = 3'b001 << $urandom_range(0, 2);
      else pat = 3'($urandom_range(1, 7));
      hi = $urandom_range(1, 10);
      lo = $urandom_range(0, 12);
      for (int c = 0; c < hi; c++) begin
        enable = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) hold(3'($urandom_range(0, 7)), 1);
        else hold(pat, 1);
      end
      hold(3'b000, lo);
    end
    enable = 1'b1;
    hold(3'b000, 20);

    // Counter wrap after 256 accepted coins.
    do_reset();
    clear_obs();
    for (int i = 0; i < 256; i++) begin
      hold(3'b001 << (i % 3), 6);
      hold(3'b000, 8);
      if (i == 254) check_val("wrap_255", coin_count, 32'd255);
    end
    hold(3'b000, 10);
    check_val("wrap_pulses", cnt_n + cnt_d + cnt_q, 32'd256);
    check_val("wrap_zero", coin_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_coin_acceptor
